// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response and decode handoff handshakes.
interface fetch_if;
    import fetch_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch PC register with hold / sequential / redirect update and target alignment check.
module fetch_pc_reg import fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);
    assign misaligned = redirect && target[1:0] != 2'b00;

    // a misaligned target leaves the PC untouched so it still names the oldest undelivered instruction
    always_ff @(posedge clk)
        if (!reset_n) pc <= RESET_VECTOR;
        else if (redirect && !misaligned) pc <= target;
        else if (advance) pc <= pc + XLEN'(INSTR_BYTES);
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch with one outstanding imem request,
// redirect squashing, boot delay and halt/resume.
module fetch_controller import fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int              BOOT_DELAY   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_if.master         bus,
    input  logic            jump_enable,
    input  logic [XLEN-1:0] jump_target_address,
    input  logic            branch_enable,
    input  logic [XLEN-1:0] branch_address,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            fetch_misaligned
);
    localparam int CW = BOOT_DELAY > 1 ? $clog2(BOOT_DELAY) : 1;

    fetch_state_t    state, state_n;
    logic [CW-1:0]   cnt;
    logic            drop, drop_n;
    logic [XLEN-1:0] pc, target, inst_data, inst_pc;
    logic            redirect, mis, apply, stop, accept, rsp, advance, capture, boot_done;

    assign redirect = state inside {REQ, WAIT, HOLD} && (jump_enable || branch_enable);
    assign target   = jump_enable ? jump_target_address : branch_address;

    fetch_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk        (clk),
        .reset_n    (reset_n),
        .redirect   (redirect),
        .target     (target),
        .advance    (advance),
        .pc         (pc),
        .misaligned (mis)
    );

    // a misaligned redirect behaves exactly like a halt request
    always_comb begin
        apply     = redirect && !mis;
        stop      = state inside {REQ, WAIT, HOLD} && (halt_req || mis);
        accept    = state == REQ && bus.imem_req_ready;
        rsp       = (state == WAIT || state == DRAIN) && bus.imem_rsp_valid;
        advance   = state == HOLD && bus.inst_ready && !stop && !apply;
        capture   = state == WAIT && rsp && !drop && !apply && !stop;
        boot_done = (BOOT_DELAY == 0) || (cnt == CW'(BOOT_DELAY - 1));
        drop_n    = rsp ? 1'b0 : (apply && (state == WAIT || accept)) ? 1'b1 : drop;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            BOOT:    state_n = boot_done ? REQ : BOOT;
            REQ:     state_n = stop ? (accept ? DRAIN : HALT) : accept ? WAIT : REQ;
            WAIT:    state_n = stop ? (rsp ? HALT : DRAIN) : rsp ? ((apply || drop) ? REQ : HOLD) : WAIT;
            HOLD:    state_n = stop ? HALT : (apply || bus.inst_ready) ? REQ : HOLD;
            DRAIN:   state_n = rsp ? HALT : DRAIN;
            HALT:    state_n = (resume && !halt_req) ? REQ : HALT;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk)
        if (!reset_n) begin
            state <= BOOT;
            cnt   <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
            cnt   <= state == BOOT ? cnt + 1'b1 : cnt;
        end

    always_ff @(posedge clk)
        if (!reset_n) begin
            inst_data        <= '0;
            inst_pc          <= '0;
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= mis;
            if (capture) begin
                inst_data <= bus.imem_rsp_data;
                inst_pc   <= pc;
            end
        end

    always_comb begin
        bus.imem_req_valid = state == REQ;
        bus.imem_req_addr  = pc;
        bus.inst_valid     = state == HOLD;
        bus.inst_data      = inst_data;
        bus.inst_pc        = inst_pc;
        halted             = state == HALT;
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and randomized checks of fetch_controller against a
// transaction-level model of fetch progress (outstanding / squash / held / halted).
module tb_fetch_controller;
    import fetch_pkg::*;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset_n, jump_enable, branch_enable, halt_req, resume, halted, fetch_misaligned;
    logic [31:0] jump_target_address, branch_address;

    always #5 clk = ~clk;

    fetch_if bus();

    fetch_controller #(.RESET_VECTOR(32'h0000_0000), .BOOT_DELAY(BD)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .bus                 (bus),
        .jump_enable         (jump_enable),
        .jump_target_address (jump_target_address),
        .branch_enable       (branch_enable),
        .branch_address      (branch_address),
        .halt_req            (halt_req),
        .resume              (resume),
        .halted              (halted),
        .fetch_misaligned    (fetch_misaligned)
    );

    int total = 0, passed = 0;
    int lat = 1;
    bit m_busy;
    int m_cnt;
    logic [31:0] m_addr;
    int boot_left;
    bit outst, discard, halt_after, have, hlt, mis_e;
    logic [31:0] pc, hdata, hpc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic bit exp_req();
        return boot_left == 0 && !hlt && !outst && !have;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic compare();
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req()));
        chk("req_addr", bus.imem_req_addr, pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(have));
        chk("inst_data", bus.inst_data, hdata);
        chk("inst_pc", bus.inst_pc, hpc);
        chk("halted", 32'(halted), 32'(hlt));
        chk("misaligned", 32'(fetch_misaligned), 32'(mis_e));
    endtask

    task automatic model_reset();
        boot_left = BD > 0 ? BD : 1;
        {outst, discard, halt_after, have, hlt, mis_e} = '0;
        pc = 32'h0; hdata = 32'h0; hpc = 32'h0;
        m_busy = 0;
    endtask

    // applies the current inputs for one clock, advances memory and model, then checks
    task automatic step();
        logic [31:0] tgt;
        bit rv, acc, accm, rsp, bad, take, stop, redir;
        rv = m_busy && m_cnt == 0;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rv ? word(m_addr) : $urandom;
        acc = bus.imem_req_valid === 1'b1 && bus.imem_req_ready;
        if (!reset_n) model_reset();
        else begin
            if (rv) m_busy = 0; else if (m_busy) m_cnt--;
            if (acc) begin m_busy = 1; m_cnt = lat - 1; m_addr = bus.imem_req_addr; end
            mis_e = 0;
            if (boot_left > 0) boot_left--;
            else if (hlt) begin
                if (resume && !halt_req) hlt = 0;
            end else if (halt_after) begin
                if (rv) begin outst = 0; halt_after = 0; hlt = 1; end
            end else begin
                accm  = exp_req() && bus.imem_req_ready;
                rsp   = outst && rv;
                redir = jump_enable || branch_enable;
                tgt   = jump_enable ? jump_target_address : branch_address;
                bad   = redir && tgt[1:0] != 2'b00;
                take  = redir && !bad;
                stop  = halt_req || bad;
                mis_e = bad;
                if (have && (take || stop)) have = 0;
                else if (have && bus.inst_ready) begin have = 0; pc = pc + 32'd4; end
                if (rsp) begin
                    outst = 0;
                    if (!discard && !take && !stop) begin have = 1; hdata = bus.imem_rsp_data; hpc = pc; end
                    discard = 0;
                end
                if (accm) begin outst = 1; discard = 0; end
                if (take) begin pc = tgt; if (outst) discard = 1; end
                if (stop) begin if (outst) halt_after = 1; else hlt = 1; end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset_n = 0; jump_enable = 0; branch_enable = 0; halt_req = 0; resume = 0;
        jump_target_address = 0; branch_address = 0;
        bus.imem_req_ready = 0; bus.inst_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
        model_reset();
        step(); step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        reset_n = 1; bus.imem_req_ready = 1; bus.inst_ready = 1;
        for (int i = 0; i < BD; i++) begin
            step();
            if (i < BD - 1) chk("boot_idle", 32'(bus.imem_req_valid), 0);
        end
        chk("first_req", 32'(bus.imem_req_valid), 1);
        chk("first_addr", bus.imem_req_addr, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(); step();
            chk("seq_valid", 32'(bus.inst_valid), 1);
            chk("seq_pc", bus.inst_pc, 32'(4 * k));
            chk("seq_data", bus.inst_data, word(32'(4 * k)));
            step();
            chk("seq_next_addr", bus.imem_req_addr, 32'(4 * (k + 1)));
        end
        lat = 2; step();
        jump_enable = 1; jump_target_address = 32'h100; step(); jump_enable = 0;
        chk("jump_wait_pc", bus.imem_req_addr, 32'h100);
        step();
        chk("jump_dropped", 32'(bus.inst_valid), 0);
        chk("jump_req", 32'(bus.imem_req_valid), 1);
        chk("jump_addr", bus.imem_req_addr, 32'h100);
        lat = 1; bus.imem_req_ready = 0; jump_enable = 1; jump_target_address = 32'h10; step();
        jump_enable = 0; bus.imem_req_ready = 1;
        chk("req_redirect_addr", bus.imem_req_addr, 32'h10);
        step(); bus.inst_ready = 0; step(); step();
        chk("hold_valid", 32'(bus.inst_valid), 1);
        chk("hold_pc", bus.inst_pc, 32'h10);
        branch_enable = 1; branch_address = 32'h40; bus.inst_ready = 1; step(); branch_enable = 0;
        chk("branch_squash", 32'(bus.inst_valid), 0);
        chk("branch_addr", bus.imem_req_addr, 32'h40);
        bus.imem_req_ready = 0; jump_enable = 1; jump_target_address = 32'h20; step();
        jump_enable = 0; bus.imem_req_ready = 1; lat = 3; step();
        halt_req = 1; step(); halt_req = 0;
        chk("drain_not_halted", 32'(halted), 0);
        step();
        chk("drain_no_req", 32'(bus.imem_req_valid), 0);
        step();
        chk("halt_entered", 32'(halted), 1);
        chk("halt_no_inst", 32'(bus.inst_valid), 0);
        resume = 1; step(); resume = 0;
        chk("resume_addr", bus.imem_req_addr, 32'h20);
        chk("resume_req", 32'(bus.imem_req_valid), 1);
        lat = 1; bus.imem_req_ready = 0; jump_enable = 1; jump_target_address = 32'h102; step(); jump_enable = 0;
        chk("mis_pulse", 32'(fetch_misaligned), 1);
        chk("mis_halted", 32'(halted), 1);
        chk("mis_pc_kept", bus.imem_req_addr, 32'h20);
        step();
        chk("mis_one_cycle", 32'(fetch_misaligned), 0);
        resume = 1; bus.imem_req_ready = 1; step(); resume = 0;
        lat = 3; step(); step();
        reset_n = 0; step(); reset_n = 1;
        chk("mid_rst_req", 32'(bus.imem_req_valid), 0);
        chk("mid_rst_data", bus.inst_data, 32'h0);
        chk("mid_rst_pc", bus.imem_req_addr, 32'h0);
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] t1, t2;
            t1 = ($urandom & 32'h3FC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            t2 = ($urandom & 32'h3FC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            reset_n = $urandom_range(0, 299) != 0;
            bus.imem_req_ready = $urandom_range(0, 9) < 7;
            bus.inst_ready = $urandom_range(0, 9) < 6;
            jump_enable = $urandom_range(0, 19) == 0;
            branch_enable = $urandom_range(0, 19) == 0;
            jump_target_address = t1;
            branch_address = t2;
            halt_req = $urandom_range(0, 24) == 0;
            resume = $urandom_range(0, 3) == 0;
            lat = $urandom_range(1, 3);
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
